// File: rtl/alu_op_issue_if.sv
// rtl/alu_op_issue_if.sv - handshake bundle between register-read, issue stage and ALU
// Purpose: groups the upstream op channel (in_*) and the downstream ALU
//   channel (out_*) of the ALU issue stage into one interface.
// Ports (signals):
//   in_valid/in_ready      upstream op handshake
//   in_aluop/in_funct      decode inputs
//   in_a/in_b/in_rd        operands and destination tag
//   out_valid/out_ready    downstream handshake toward the ALU
//   out_aluctl/out_a/out_b/out_rd/out_illegal  head entry presented to the ALU
// Modports:
//   slave   the issue stage itself
//   master  the surrounding pipeline (register-read producer + ALU consumer)
interface alu_op_issue_if #(
  parameter int DW  = 32,
  parameter int RDW = 5
);
  logic           in_valid;
  logic           in_ready;
  logic [1:0]     in_aluop;
  logic [5:0]     in_funct;
  logic [DW-1:0]  in_a;
  logic [DW-1:0]  in_b;
  logic [RDW-1:0] in_rd;
  logic           out_valid;
  logic           out_ready;
  logic [3:0]     out_aluctl;
  logic [DW-1:0]  out_a;
  logic [DW-1:0]  out_b;
  logic [RDW-1:0] out_rd;
  logic           out_illegal;

  modport slave (
    input  in_valid, in_aluop, in_funct, in_a, in_b, in_rd, out_ready,
    output in_ready, out_valid, out_aluctl, out_a, out_b, out_rd, out_illegal
  );

  modport master (
    output in_valid, in_aluop, in_funct, in_a, in_b, in_rd, out_ready,
    input  in_ready, out_valid, out_aluctl, out_a, out_b, out_rd, out_illegal
  );
endinterface

// File: rtl/alu_op_issue.sv
// rtl/alu_op_issue.sv - ALU issue stage: ALUOp/funct decode with a 2-entry skid buffer
// Purpose: accepts decoded ops from register-read, translates ALUOp/funct into
//   the 4-bit ALU control code and holds up to two ops so downstream stalls
//   never drop work. Undecodable ops flow through in order, flagged, and are
//   counted in a saturating counter.
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   bus          alu_op_issue_if.slave (in_* upstream channel, out_* ALU channel)
//   illegal_cnt  saturating count of accepted illegal ops
module alu_op_issue #(
  parameter int         DW          = 32,
  parameter int         RDW         = 5,
  parameter int         CNTW        = 16,
  parameter logic [3:0] ILLEGAL_CTL = 4'd15
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_op_issue_if.slave   bus,
  output logic [CNTW-1:0] illegal_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  typedef struct packed {
    logic [3:0]     ctl;
    logic [DW-1:0]  a;
    logic [DW-1:0]  b;
    logic [RDW-1:0] rd;
    logic           ill;
  } entry_t;

  state_t state;
  state_t state_nx;
  entry_t head;
  entry_t tail;
  entry_t new_e;
  logic   in_ready_q;
  logic   out_valid_q;
  logic   push;
  logic   pop;
  logic [3:0] dec_ctl;
  logic       dec_ill;

  assign push = bus.in_valid & in_ready_q;
  assign pop  = out_valid_q & bus.out_ready;

  always_comb begin
    dec_ctl = ILLEGAL_CTL;
    dec_ill = 1'b1;
    case (bus.in_aluop)
      2'b00: begin dec_ctl = 4'd2; dec_ill = 1'b0; end
      2'b01: begin dec_ctl = 4'd6; dec_ill = 1'b0; end
      2'b10: begin
        case (bus.in_funct)
          6'd32: begin dec_ctl = 4'd2;  dec_ill = 1'b0; end
          6'd34: begin dec_ctl = 4'd6;  dec_ill = 1'b0; end
          6'd36: begin dec_ctl = 4'd0;  dec_ill = 1'b0; end
          6'd37: begin dec_ctl = 4'd1;  dec_ill = 1'b0; end
          6'd39: begin dec_ctl = 4'd12; dec_ill = 1'b0; end
          6'd42: begin dec_ctl = 4'd7;  dec_ill = 1'b0; end
          default: begin dec_ctl = ILLEGAL_CTL; dec_ill = 1'b1; end
        endcase
      end
      default: begin dec_ctl = ILLEGAL_CTL; dec_ill = 1'b1; end
    endcase
  end

  always_comb begin
    new_e.ctl = dec_ctl;
    new_e.a   = bus.in_a;
    new_e.b   = bus.in_b;
    new_e.rd  = bus.in_rd;
    new_e.ill = dec_ill;
  end

  // Push cannot occur in TWO because in_ready is already low there.
  always_comb begin
    state_nx = state;
    case (state)
      EMPTY: if (push) state_nx = ONE;
      ONE: begin
        if (push && !pop)      state_nx = TWO;
        else if (!push && pop) state_nx = EMPTY;
      end
      TWO:   if (pop) state_nx = ONE;
      default: state_nx = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= EMPTY;
      head        <= '0;
      tail        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state       <= state_nx;
      // Ready/valid are derived from the next state so both are plain flops.
      in_ready_q  <= (state_nx != TWO);
      out_valid_q <= (state_nx != EMPTY);
      case (state)
        EMPTY: if (push) head <= new_e;
        ONE: begin
          // With a simultaneous pop the new op replaces the departing head.
          if (push && pop) head <= new_e;
          else if (push)   tail <= new_e;
        end
        TWO:   if (pop) head <= tail;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_cnt <= '0;
    end else if (push && dec_ill && (illegal_cnt != {CNTW{1'b1}})) begin
      illegal_cnt <= illegal_cnt + 1'b1;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_aluctl  = head.ctl;
  assign bus.out_a       = head.a;
  assign bus.out_b       = head.b;
  assign bus.out_rd      = head.rd;
  assign bus.out_illegal = head.ill;

endmodule

// File: tb/tb_alu_op_issue.sv
// tb/tb_alu_op_issue.sv - self-checking bench for alu_op_issue with a scoreboard
module tb_alu_op_issue;
  localparam int DW = 32;
  localparam int RDW = 5;
  localparam int CNTW = 16;

  typedef struct packed {
    logic [3:0]     ctl;
    logic [DW-1:0]  a;
    logic [DW-1:0]  b;
    logic [RDW-1:0] rd;
    logic           ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_op_issue_if #(.DW(DW), .RDW(RDW)) bus ();
  alu_op_issue_if #(.DW(DW), .RDW(RDW)) bus_s ();
  logic [CNTW-1:0] illegal_cnt;
  logic [1:0]      cnt_small;

  alu_op_issue #(.DW(DW), .RDW(RDW), .CNTW(CNTW)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .illegal_cnt(illegal_cnt)
  );

  alu_op_issue #(.DW(DW), .RDW(RDW), .CNTW(2)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .bus(bus_s), .illegal_cnt(cnt_small)
  );

  int checks = 0;
  int errors = 0;
  int pops = 0;
  int exp_cnt = 0;
  bit last_push;
  bit last_pop;
  exp_t sb[$];

  function automatic exp_t model(logic [1:0] op, logic [5:0] f, logic [DW-1:0] a,
                                 logic [DW-1:0] b, logic [RDW-1:0] rd);
    exp_t e;
    e.a = a; e.b = b; e.rd = rd; e.ctl = 4'd15; e.ill = 1'b1;
    if (op == 2'b00) begin e.ctl = 4'd2; e.ill = 1'b0; end
    else if (op == 2'b01) begin e.ctl = 4'd6; e.ill = 1'b0; end
    else if (op == 2'b10) begin
      case (f)
        6'd32: begin e.ctl = 4'd2;  e.ill = 1'b0; end
        6'd34: begin e.ctl = 4'd6;  e.ill = 1'b0; end
        6'd36: begin e.ctl = 4'd0;  e.ill = 1'b0; end
        6'd37: begin e.ctl = 4'd1;  e.ill = 1'b0; end
        6'd39: begin e.ctl = 4'd12; e.ill = 1'b0; end
        6'd42: begin e.ctl = 4'd7;  e.ill = 1'b0; end
        default: ;
      endcase
    end
    return e;
  endfunction

  // Advance one clock: sample handshakes at the falling edge, compare any pop
  // against the scoreboard, record any push, then return just after the rising edge.
  task automatic clock_cycle();
    exp_t e;
    exp_t act;
    @(negedge clk);
    last_push = 1'b0;
    last_pop = 1'b0;
    if (bus.out_valid && bus.out_ready) begin
      last_pop = 1'b1;
      pops++;
      checks++;
      act.ctl = bus.out_aluctl; act.a = bus.out_a; act.b = bus.out_b;
      act.rd = bus.out_rd; act.ill = bus.out_illegal;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_pop unexpected output got %h expected none", act);
      end else begin
        e = sb.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL sb_pop got ctl=%0d a=%h b=%h rd=%0d ill=%b expected ctl=%0d a=%h b=%h rd=%0d ill=%b",
                   act.ctl, act.a, act.b, act.rd, act.ill, e.ctl, e.a, e.b, e.rd, e.ill);
        end
      end
    end
    if (bus.in_valid && bus.in_ready) begin
      last_push = 1'b1;
      e = model(bus.in_aluop, bus.in_funct, bus.in_a, bus.in_b, bus.in_rd);
      sb.push_back(e);
      if (e.ill) exp_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(logic [1:0] op, logic [5:0] f, logic [DW-1:0] a,
                        logic [DW-1:0] b, logic [RDW-1:0] rd);
    bus.in_aluop = op; bus.in_funct = f; bus.in_a = a; bus.in_b = b; bus.in_rd = rd;
  endtask

  task automatic send(logic [1:0] op, logic [5:0] f, logic [DW-1:0] a,
                      logic [DW-1:0] b, logic [RDW-1:0] rd);
    int n = 0;
    set_op(op, f, a, b, rd);
    bus.in_valid = 1'b1;
    do begin
      clock_cycle();
      n++;
    end while (!last_push && n < 20);
    bus.in_valid = 1'b0;
    if (!last_push) begin
      checks++; errors++;
      $display("FAIL send_timeout got no accept expected accept within 20 clks");
    end
  endtask

  task automatic drain();
    int n = 0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    while (sb.size() != 0 && n < 20) begin
      clock_cycle();
      n++;
    end
    checks++;
    if (sb.size() != 0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain left=%0d out_valid=%b expected left=0 out_valid=0", sb.size(), bus.out_valid);
    end
  endtask

  task automatic check_reset_values(string tag);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_aluctl !== 4'd0 ||
        bus.out_a !== '0 || bus.out_b !== '0 || bus.out_rd !== '0 ||
        bus.out_illegal !== 1'b0 || illegal_cnt !== '0) begin
      errors++;
      $display("FAIL %s got rdy=%b vld=%b ctl=%0d a=%h b=%h rd=%0d ill=%b cnt=%0d expected rdy=1 rest=0",
               tag, bus.in_ready, bus.out_valid, bus.out_aluctl, bus.out_a, bus.out_b,
               bus.out_rd, bus.out_illegal, illegal_cnt);
    end
  endtask

  task automatic test_reset();
    bus.in_valid = 0; bus.out_ready = 0; set_op(0, 0, 0, 0, 0);
    bus_s.in_valid = 0; bus_s.out_ready = 0; bus_s.in_aluop = 0; bus_s.in_funct = 0;
    bus_s.in_a = 0; bus_s.in_b = 0; bus_s.in_rd = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset_initial");
    rst_n = 1'b1;
    clock_cycle();
  endtask

  task automatic test_single();
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL single_pre out_valid=%b expected 0", bus.out_valid);
    end
    send(2'b10, 6'd32, 32'd1, 32'd1, 5'd3);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_aluctl !== 4'd2 || bus.out_a !== 32'd1 ||
        bus.out_b !== 32'd1 || bus.out_rd !== 5'd3) begin
      errors++;
      $display("FAIL single got vld=%b ctl=%0d a=%0d b=%0d rd=%0d expected vld=1 ctl=2 a=1 b=1 rd=3",
               bus.out_valid, bus.out_aluctl, bus.out_a, bus.out_b, bus.out_rd);
    end
    drain();
  endtask

  task automatic test_decode_sweep();
    logic [5:0] fn [6];
    fn = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42};
    bus.out_ready = 1'b1;
    foreach (fn[i]) send(2'b10, fn[i], $urandom, $urandom, RDW'(i + 1));
    send(2'b00, 6'd5, $urandom, $urandom, 5'd10);
    send(2'b01, 6'd36, $urandom, $urandom, 5'd11);
    drain();
  endtask

  task automatic test_backpressure();
    int z_taken = 0;
    bus.out_ready = 1'b0;
    send(2'b10, 6'd34, 32'hA, 32'h1, 5'd1);
    send(2'b10, 6'd36, 32'hB, 32'h2, 5'd2);
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_a !== 32'hA) begin
      errors++;
      $display("FAIL bp_full got in_ready=%b out_a=%h expected in_ready=0 out_a=a", bus.in_ready, bus.out_a);
    end
    set_op(2'b10, 6'd37, 32'hC, 32'h3, 5'd4);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      clock_cycle();
      checks++;
      if (last_push !== 1'b0 || bus.out_a !== 32'hA || bus.out_aluctl !== 4'd6) begin
        errors++;
        $display("FAIL bp_hold got push=%b out_a=%h ctl=%0d expected push=0 out_a=a ctl=6",
                 last_push, bus.out_a, bus.out_aluctl);
      end
    end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      clock_cycle();
      if (last_push) begin bus.in_valid = 1'b0; z_taken++; end
      checks++;
      if (last_pop !== 1'b1) begin
        errors++; $display("FAIL bp_release cycle %0d got pop=0 expected pop=1", k);
      end
    end
    checks++;
    if (z_taken != 1) begin
      errors++; $display("FAIL bp_z_accept got %0d expected 1", z_taken);
    end
    drain();
  endtask

  task automatic test_illegal();
    bus.out_ready = 1'b1;
    send(2'b10, 6'd0, 32'h11, 32'h22, 5'd7);
    send(2'b11, 6'd32, 32'h33, 32'h44, 5'd8);
    drain();
    checks++;
    if (illegal_cnt !== CNTW'(2) || exp_cnt != 2) begin
      errors++; $display("FAIL illegal_cnt got %0d expected 2", illegal_cnt);
    end
  endtask

  task automatic test_streaming();
    int p0 = pops;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      set_op(2'(k % 3), 6'd32, 32'(k * 3), 32'(k + 100), 5'(k));
      clock_cycle();
      checks++;
      if (last_push !== 1'b1 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL stream cycle %0d got push=%b in_ready=%b out_valid=%b expected 1 1 1",
                 k, last_push, bus.in_ready, bus.out_valid);
      end
    end
    bus.in_valid = 1'b0;
    clock_cycle();
    checks++;
    if (pops - p0 != 8 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL stream_count got %0d expected 8", pops - p0);
    end
  endtask

  task automatic test_reset_midstream();
    bus.out_ready = 1'b0;
    send(2'b00, 6'd0, 32'h55, 32'h66, 5'd9);
    send(2'b11, 6'd0, 32'h77, 32'h88, 5'd12);
    checks++;
    if (illegal_cnt !== CNTW'(exp_cnt) || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL pre_reset got cnt=%0d in_ready=%b expected cnt=%0d in_ready=0",
               illegal_cnt, bus.in_ready, exp_cnt);
    end
    set_op(2'b01, 6'd0, 32'h99, 32'h1, 5'd1);
    bus.in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    bus.in_valid = 1'b0;
    check_reset_values("reset_midstream");
    sb.delete();
    exp_cnt = 0;
    @(posedge clk);
    #1;
    check_reset_values("reset_held");
    rst_n = 1'b1;
    clock_cycle();
    send(2'b10, 6'd42, 32'h5, 32'h6, 5'd30);
    drain();
  endtask

  task automatic test_counter_sat();
    checks++;
    if (cnt_small !== 2'd0) begin
      errors++; $display("FAIL sat_start got %0d expected 0", cnt_small);
    end
    bus_s.out_ready = 1'b1;
    bus_s.in_aluop = 2'b11;
    bus_s.in_valid = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (cnt_small !== 2'((k > 3) ? 3 : k) || bus_s.out_illegal !== 1'b1 || bus_s.out_aluctl !== 4'd15) begin
        errors++;
        $display("FAIL sat_cnt step %0d got cnt=%0d ill=%b ctl=%0d expected cnt=%0d ill=1 ctl=15",
                 k, cnt_small, bus_s.out_illegal, bus_s.out_aluctl, (k > 3) ? 3 : k);
      end
    end
    bus_s.in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_decode_sweep();
    test_backpressure();
    test_illegal();
    test_streaming();
    test_reset_midstream();
    test_counter_sat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
